seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 37 +++
 rtl/seq_alu_if.sv | 22 ++
 rtl/shift_add_mul.sv | 50 +++++
 rtl/seq_alu.sv | 128 ++++++++++++
 tb/tb_seq_alu.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and flag bit positions for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LSL = 3'b101,
    OP_LSR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f        = '0;
    f[N_IDX] = n;
    f[Z_IDX] = z;
    f[C_IDX] = c;
    f[V_IDX] = v;
    return f;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response handshake bundle between a requester and seq_alu.
interface seq_alu_if #(parameter int WIDTH = 32);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       ALUControl;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;

  modport master (
    output InValid, a, b, ALUControl, OutReady,
    input  InReady, OutValid, Result, ALUFlags
  );

  modport slave (
    input  InValid, a, b, ALUControl, OutReady,
    output InReady, OutValid, Result, ALUFlags
  );
endinterface

// File: rtl/shift_add_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic             product_hi_nz
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;

  // Low half starts as the multiplier; its LSB selects the add, then all shifts right.
  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};

  // Outputs reflect the step being taken this cycle, so the final edge can load them.
  assign done          = r_busy && (r_cnt == CW'(WIDTH-1));
  assign product_lo    = w_prod_nxt[WIDTH-1:0];
  assign product_hi_nz = |w_prod_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (start) begin
      r_mcand <= a;
      r_prod  <= {{WIDTH{1'b0}}, b};
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_prod <= w_prod_nxt;
      r_cnt  <= r_cnt + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ADD/SUB/logic/shift ops, WIDTH-cycle shift-add MUL.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("seq_alu: WIDTH must be a power of two between 8 and 64");
  end

  state_e           r_state, w_state_nxt;
  logic             w_in_ready, w_out_valid, w_accept, w_is_mul;
  logic             w_mul_done, w_mul_hi_nz;
  logic [WIDTH-1:0] w_mul_lo;
  alu_op_e          w_op;

  logic [WIDTH-1:0] w_b_op, w_res;
  logic [WIDTH:0]   w_add, w_shl, w_shr;
  logic             w_c, w_v;
  logic [3:0]       w_flags;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  assign w_op     = alu_op_e'(bus.ALUControl);
  assign w_is_mul = (w_op == OP_MUL);
  assign w_accept = bus.InValid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
      S_MUL:  if (w_mul_done) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_accept)          w_state_nxt = w_is_mul ? S_MUL : S_DONE;
        else if (bus.OutReady) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: w_in_ready = 1'b1;
      S_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.OutReady;
      end
      default: ;
    endcase
  end

  // One adder serves ADD and SUB: SUB is a + ~b + 1, selected by opcode bit 0.
  assign w_b_op = bus.ALUControl[0] ? ~bus.b : bus.b;
  assign w_add  = {1'b0, bus.a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, bus.ALUControl[0]};
  // The extra bit catches the last bit shifted out; it stays 0 for a zero shift.
  assign w_shl  = {1'b0, bus.a} << bus.b[SHW-1:0];
  assign w_shr  = {bus.a, 1'b0} >> bus.b[SHW-1:0];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (bus.a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_add[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: w_res = bus.a & bus.b;
      OP_OR:  w_res = bus.a | bus.b;
      OP_XOR: w_res = bus.a ^ bus.b;
      OP_LSL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_LSR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      default: ;
    endcase
  end

  assign w_flags = pack_flags(w_res[WIDTH-1], ~|w_res, w_c, w_v);

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (w_accept && w_is_mul),
    .a            (bus.a),
    .b            (bus.b),
    .done         (w_mul_done),
    .product_lo   (w_mul_lo),
    .product_hi_nz(w_mul_hi_nz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_res;
      r_flags  <= w_flags;
    end else if (r_state == S_MUL && w_mul_done) begin
      r_result <= w_mul_lo;
      r_flags  <= pack_flags(w_mul_lo[WIDTH-1], ~|w_mul_lo, w_mul_hi_nz, 1'b0);
    end
  end

  assign bus.InReady  = w_in_ready;
  assign bus.OutValid = w_out_valid;
  assign bus.Result   = r_result;
  assign bus.ALUFlags = r_flags;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=32: directed, random, MUL, flow-control and reset cases.
module tb_seq_alu;
  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus();
  seq_alu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sr;
    int          sh;
    logic        c, v;
    sh = int'(b[4:0]);
    c = 1'b0; v = 1'b0; e.res = '0;
    case (op)
      3'd0: begin
        p = 64'(a) + 64'(b); e.res = p[31:0]; c = p[32];
        sr = longint'($signed(a)) + longint'($signed(b));
        v = (sr != longint'($signed(e.res)));
      end
      3'd1: begin
        p = 64'(a) - 64'(b); e.res = p[31:0]; c = (a >= b);
        sr = longint'($signed(a)) - longint'($signed(b));
        v = (sr != longint'($signed(e.res)));
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin e.res = a << sh; c = (sh == 0) ? 1'b0 : a[32-sh]; end
      3'd6: begin e.res = a >> sh; c = (sh == 0) ? 1'b0 : a[sh-1]; end
      default: begin p = 64'(a) * 64'(b); e.res = p[31:0]; c = |p[63:32]; end
    endcase
    e.flg = {e.res[31], (e.res == 32'd0), c, v};
    return e;
  endfunction

  // Drive at a falling edge, hold until accepted, return at the falling edge after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus.ALUControl = op; bus.a = a; bus.b = b; bus.InValid = 1'b1;
    sb.push_back(model(op, a, b));
    while (bus.InReady !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL issue_timeout InReady=%b required 1", bus.InReady); end
    @(negedge clk);
    bus.InValid = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.ALUControl = 3'($urandom);
  endtask

  task automatic test_reset();
    bus.InValid = 1'b0; bus.OutReady = 1'b1; bus.a = '0; bus.b = '0; bus.ALUControl = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.OutValid !== 1'b0 || bus.Result !== 32'd0 || bus.ALUFlags !== 4'd0) begin
      errors++; $display("FAIL reset_state got v=%b r=%h f=%b required 0/0/0", bus.OutValid, bus.Result, bus.ALUFlags);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.InReady !== 1'b1) begin errors++; $display("FAIL reset_inready got %b required 1", bus.InReady); end
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    vec_t        v[3];
    logic [35:0] lit[3];
    exp_t        e;
    v[0] = {3'd0, 32'h7FFFFFFF, 32'd1}; lit[0] = {32'h80000000, 4'b1001};
    v[1] = {3'd1, 32'd5, 32'd5};        lit[1] = {32'h00000000, 4'b0110};
    v[2] = {3'd1, 32'd3, 32'd5};        lit[2] = {32'hFFFFFFFE, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      e = sb.pop_front();
      checks++;
      if (bus.OutValid !== 1'b1 || {bus.Result, bus.ALUFlags} !== lit[i]) begin
        errors++; $display("FAIL spec_vec%0d got v=%b r=%h f=%b required r=%h f=%b", i, bus.OutValid, bus.Result, bus.ALUFlags, lit[i][35:4], lit[i][3:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_ops();
    vec_t v[$];
    exp_t e;
    v.push_back({3'd0, 32'hFFFFFFFF, 32'd1});
    v.push_back({3'd1, 32'h80000000, 32'd1});
    v.push_back({3'd1, 32'h7FFFFFFF, 32'hFFFFFFFF});
    v.push_back({3'd2, 32'hF0F0F0F0, 32'h0F0F0F0F});
    v.push_back({3'd3, 32'h80000000, 32'h00000001});
    v.push_back({3'd4, 32'hA5A5A5A5, 32'hFFFFFFFF});
    v.push_back({3'd5, 32'h12345678, 32'd0});
    v.push_back({3'd5, 32'h80000001, 32'd31});
    v.push_back({3'd6, 32'h00000001, 32'd1});
    v.push_back({3'd6, 32'hFFFFFFFF, 32'd63});
    v.push_back({3'd6, 32'h80000000, 32'd0});
    for (int i = 0; i < 16; i++) v.push_back({3'($urandom_range(0, 6)), 32'($urandom), 32'($urandom)});
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b);
      e = sb.pop_front();
      checks++;
      if (bus.OutValid !== 1'b1 || bus.Result !== e.res || bus.ALUFlags !== e.flg) begin
        errors++; $display("FAIL alu_op%0d op=%0d got v=%b r=%h f=%b required r=%h f=%b", i, v[i].op, bus.OutValid, bus.Result, bus.ALUFlags, e.res, e.flg);
      end
      if (i % 2 == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_mul();
    vec_t v[$];
    exp_t e;
    logic ok;
    v.push_back({3'd7, 32'h00010000, 32'h00010000});
    v.push_back({3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF});
    v.push_back({3'd7, 32'd12345, 32'd6789});
    v.push_back({3'd7, 32'($urandom), 32'($urandom)});
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b);
      ok = 1'b1;
      for (int k = 1; k <= 32; k++) begin
        if (bus.InReady !== 1'b0 || bus.OutValid !== 1'b0) ok = 1'b0;
        @(negedge clk);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL mul%0d_busy got early ready/valid required 32 busy cycles", i); end
      e = sb.pop_front();
      checks++;
      if (bus.OutValid !== 1'b1 || bus.Result !== e.res || bus.ALUFlags !== e.flg) begin
        errors++; $display("FAIL mul%0d_result got v=%b r=%h f=%b required r=%h f=%b", i, bus.OutValid, bus.Result, bus.ALUFlags, e.res, e.flg);
      end
      if (i == 0) begin
        checks++;
        if (bus.Result !== 32'd0 || bus.ALUFlags !== 4'b0110) begin
          errors++; $display("FAIL mul_spec got r=%h f=%b required 0/0110", bus.Result, bus.ALUFlags);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    vec_t v[3];
    bus.OutReady = 1'b1;
    v[0] = {3'd3, 32'h0F0F0000, 32'h00F0F0F0};
    v[1] = {3'd4, 32'hFFFF0000, 32'h12345678};
    v[2] = {3'd5, 32'h80000001, 32'd1};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        checks++;
        if (bus.InReady !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b required 1", i, bus.InReady); end
      end
      issue(v[i].op, v[i].a, v[i].b);
      e = sb.pop_front();
      checks++;
      if (bus.OutValid !== 1'b1 || bus.Result !== e.res || bus.ALUFlags !== e.flg) begin
        errors++; $display("FAIL b2b%0d got v=%b r=%h f=%b required r=%h f=%b", i, bus.OutValid, bus.Result, bus.ALUFlags, e.res, e.flg);
      end
    end
    checks++;
    if (bus.Result !== 32'h00000002 || bus.ALUFlags !== 4'b0010) begin
      errors++; $display("FAIL b2b_last got r=%h f=%b required 00000002/0010", bus.Result, bus.ALUFlags);
    end
    @(negedge clk);
    checks++;
    if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL b2b_idle got v=%b required 0", bus.OutValid); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic ok;
    bus.OutReady = 1'b0;
    issue(3'd2, 32'hDEADBEEF, 32'hFF00FF00);
    e = sb.pop_front();
    checks++;
    if (bus.OutValid !== 1'b1 || bus.Result !== e.res || bus.ALUFlags !== e.flg) begin
      errors++; $display("FAIL bp_and got v=%b r=%h f=%b required r=%h f=%b", bus.OutValid, bus.Result, bus.ALUFlags, e.res, e.flg);
    end
    // A pending XOR must wait out the stall and then hand off on the releasing edge.
    bus.ALUControl = 3'd4; bus.a = 32'h0000FFFF; bus.b = 32'h0000FFFF; bus.InValid = 1'b1;
    sb.push_back(model(3'd4, 32'h0000FFFF, 32'h0000FFFF));
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.OutValid !== 1'b1 || bus.Result !== e.res || bus.ALUFlags !== e.flg || bus.InReady !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_hold got v=%b r=%h f=%b rdy=%b required stable r=%h f=%b rdy=0", bus.OutValid, bus.Result, bus.ALUFlags, bus.InReady, e.res, e.flg); end
    bus.OutReady = 1'b1;
    #1;
    checks++;
    if (bus.InReady !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b required 1", bus.InReady); end
    @(negedge clk);
    bus.InValid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (bus.OutValid !== 1'b1 || bus.Result !== e.res || bus.ALUFlags !== e.flg) begin
      errors++; $display("FAIL bp_handoff got v=%b r=%h f=%b required r=%h f=%b", bus.OutValid, bus.Result, bus.ALUFlags, e.res, e.flg);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    exp_t e;
    logic ok;
    bus.OutReady = 1'b1;
    issue(3'd2, 32'hF0F0F0F0, 32'hFF00FF00);
    e = sb.pop_front();
    checks++;
    if (bus.Result !== e.res) begin errors++; $display("FAIL rst_pre got r=%h required %h", bus.Result, e.res); end
    issue(3'd7, 32'h00001234, 32'h00005678);
    repeat (9) @(negedge clk);
    checks++;
    if (bus.InReady !== 1'b0) begin errors++; $display("FAIL rst_in_mul got rdy=%b required 0", bus.InReady); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.OutValid !== 1'b0 || bus.Result !== 32'd0 || bus.ALUFlags !== 4'd0) begin
      errors++; $display("FAIL rst_mid got v=%b r=%h f=%b required 0/0/0", bus.OutValid, bus.Result, bus.ALUFlags);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.OutValid !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_no_partial got OutValid=1 required 0 after abort"); end
    issue(3'd0, 32'd2, 32'd3);
    e = sb.pop_front();
    checks++;
    if (bus.OutValid !== 1'b1 || bus.Result !== 32'd5 || bus.Result !== e.res || bus.ALUFlags !== e.flg) begin
      errors++; $display("FAIL rst_add got v=%b r=%h f=%b required r=00000005 f=%b", bus.OutValid, bus.Result, bus.ALUFlags, e.flg);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_alu_ops();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
